// File: rtl/ascon_pinv_pkg.sv
// ascon_pinv_pkg - shared types, constants and helpers for the inverse Ascon
// permutation: state type, FSM states, inverse S-box table, linear-layer
// rotation pairs, round-constant function and one inverse-linear squaring step.
package ascon_pinv_pkg;

  localparam int NR_MAX     = 12;
  localparam int LINV_STEPS = 6;

  // Five 64-bit words; index 0 is x0 (S-box column MSB).
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    PINV_IDLE,
    PINV_LINV,
    PINV_SBOX,
    PINV_DONE
  } type_pinv_fsm;

  // Inverse of the 5-bit Ascon S-box, indexed by {x0,x1,x2,x3,x4}.
  localparam logic [4:0] INV_SBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  // Rotation pairs of the forward linear layer, per word.
  localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

  // Round constant for round index r, placed in the low byte of x2.
  function automatic logic [63:0] round_const(input logic [3:0] r);
    return {56'd0, 4'd15 - r, r};
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    int unsigned m;
    m = n % 64;
    return (x >> m) | (x << ((64 - m) % 64));
  endfunction

  // Squaring step k of the inverse linear layer: with L = 1 + r^a + r^b,
  // L^(2^k) = 1 + r^(2^k a) + r^(2^k b), and the product over k=0..5 is L^63 = L^-1.
  function automatic type_state linv_step(input type_state s, input int unsigned k);
    type_state r;
    for (int i = 0; i < 5; i++) begin
      r[i] = s[i] ^ rotr64(s[i], (ROT_A[i] << k) % 64) ^ rotr64(s[i], (ROT_B[i] << k) % 64);
    end
    return r;
  endfunction

endpackage

// File: rtl/ascon_pinv_sbox.sv
// ascon_pinv_sbox - combinational 320-bit inverse substitution layer:
// 64 independent 5-bit column lookups, x0 as the column MSB.
module ascon_pinv_sbox
  import ascon_pinv_pkg::*;
(
  input  type_state x,
  output type_state y
);

  logic [4:0] col_out [64];

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_col
      logic [4:0] col_in;
      assign col_in      = {x[0][gi], x[1][gi], x[2][gi], x[3][gi], x[4][gi]};
      assign col_out[gi] = INV_SBOX[col_in];
    end
  endgenerate

  // Scatter each looked-up column back across the five words.
  always_comb begin
    y = '0;
    for (int i = 0; i < 64; i++) begin
      y[0][i] = col_out[i][4];
      y[1][i] = col_out[i][3];
      y[2][i] = col_out[i][2];
      y[3][i] = col_out[i][1];
      y[4][i] = col_out[i][0];
    end
  end

endmodule

// File: rtl/ascon_pinv.sv
// ascon_pinv - iterative inverse Ascon permutation p^-a (undoes pl, ps, pc per
// round, last round first) on one shared 320-bit state register.
// Optional: define ASCON_PINV_FAST_LINV_EN to cascade all six inverse-linear
// squaring steps into a single LINV cycle (latency 1+2a instead of 1+7a).
module ascon_pinv
  import ascon_pinv_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] nrounds_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o
);

  type_pinv_fsm fsm_reg;
  type_state    state_reg;
  logic [3:0]   rnd_reg;
  logic [3:0]   stop_reg;
  logic         busy_reg;
  logic         done_reg;

  logic [3:0]   nrounds_eff;
  type_state    lin_step [LINV_STEPS];
  type_state    linv_out;
  type_state    sbox_out;
  type_state    round_out;
  logic         linv_last;

  // Out-of-range round requests run the full permutation.
  assign nrounds_eff = (nrounds_i == 4'd0 || nrounds_i > 4'(NR_MAX)) ? 4'(NR_MAX) : nrounds_i;

  genvar gi;
`ifdef ASCON_PINV_FAST_LINV_EN
  generate
    for (gi = 0; gi < LINV_STEPS; gi++) begin : g_linv
      if (gi == 0) begin : g_first
        assign lin_step[gi] = linv_step(state_reg, gi);
      end else begin : g_next
        assign lin_step[gi] = linv_step(lin_step[gi-1], gi);
      end
    end
  endgenerate

  assign linv_out  = lin_step[LINV_STEPS-1];
  assign linv_last = 1'b1;
`else
  logic [2:0] k_reg;

  generate
    for (gi = 0; gi < LINV_STEPS; gi++) begin : g_linv
      assign lin_step[gi] = linv_step(state_reg, gi);
    end
  endgenerate

  // Pick the squaring step selected by the linear-step counter.
  always_comb begin
    linv_out = state_reg;
    for (int k = 0; k < LINV_STEPS; k++) begin
      if (k_reg == 3'(k)) linv_out = lin_step[k];
    end
  end

  assign linv_last = (k_reg == 3'(LINV_STEPS - 1));

  // Linear-step counter: cleared on accept and between rounds.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      k_reg <= '0;
    end else if (fsm_reg == PINV_LINV) begin
      k_reg <= linv_last ? 3'd0 : k_reg + 3'd1;
    end else begin
      k_reg <= '0;
    end
  end
`endif

  ascon_pinv_sbox u_sbox (
    .x (state_reg),
    .y (sbox_out)
  );

  // Inverse substitution followed by removal of this round's constant.
  always_comb begin
    round_out    = sbox_out;
    round_out[2] = sbox_out[2] ^ round_const(rnd_reg);
  end

  // Sequencer: accept, alternate LINV/SBOX per round, pulse done once.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_reg   <= PINV_IDLE;
      state_reg <= '0;
      rnd_reg   <= '0;
      stop_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (fsm_reg)
        PINV_IDLE: begin
          done_reg <= 1'b0;
          if (start_i) begin
            state_reg <= state_i;
            rnd_reg   <= 4'(NR_MAX - 1);
            stop_reg  <= 4'(NR_MAX) - nrounds_eff;
            busy_reg  <= 1'b1;
            fsm_reg   <= PINV_LINV;
          end
        end
        PINV_LINV: begin
          state_reg <= linv_out;
          if (linv_last) fsm_reg <= PINV_SBOX;
        end
        PINV_SBOX: begin
          state_reg <= round_out;
          if (rnd_reg == stop_reg) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            fsm_reg  <= PINV_DONE;
          end else begin
            rnd_reg <= rnd_reg - 4'd1;
            fsm_reg <= PINV_LINV;
          end
        end
        PINV_DONE: begin
          done_reg <= 1'b0;
          fsm_reg  <= PINV_IDLE;
        end
        default: fsm_reg <= PINV_IDLE;
      endcase
    end
  end

  assign state_o = state_reg;
  assign busy_o  = busy_reg;
  assign done_o  = done_reg;

endmodule

// File: tb/tb_ascon_pinv.sv
// tb_ascon_pinv - self-checking bench for ascon_pinv. Expected results come from
// a forward Ascon permutation model (pc, ps, pl): a state pushed forward by a
// rounds must come back unchanged through the inverse.
module tb_ascon_pinv;

  typedef logic [4:0][63:0] st_t;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [3:0] nrounds_i;
  st_t        state_i;
  st_t        state_o;
  logic       busy_o;
  logic       done_o;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] SBOX_FWD [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  ascon_pinv dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .nrounds_i (nrounds_i),
    .state_i   (state_i),
    .state_o   (state_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic st_t mk(input logic [63:0] x0, input logic [63:0] x1,
                             input logic [63:0] x2, input logic [63:0] x3,
                             input logic [63:0] x4);
    st_t s;
    s[0] = x0; s[1] = x1; s[2] = x2; s[3] = x3; s[4] = x4;
    return s;
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One forward Ascon round with round index r.
  function automatic st_t fwd_round(input st_t s, input int r);
    st_t t, u, o;
    logic [4:0] c, v;
    int ra [5];
    int rb [5];
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    t = s;
    t[2] = t[2] ^ 64'(((15 - r) << 4) | r);
    for (int i = 0; i < 64; i++) begin
      c = {t[0][i], t[1][i], t[2][i], t[3][i], t[4][i]};
      v = SBOX_FWD[c];
      u[0][i] = v[4]; u[1][i] = v[3]; u[2][i] = v[2]; u[3][i] = v[1]; u[4][i] = v[0];
    end
    for (int j = 0; j < 5; j++) o[j] = u[j] ^ ror(u[j], ra[j]) ^ ror(u[j], rb[j]);
    return o;
  endfunction

  function automatic st_t fwd_perm(input st_t s, input int a);
    st_t t;
    t = s;
    for (int r = 12 - a; r < 12; r++) t = fwd_round(t, r);
    return t;
  endfunction

  function automatic int eff_rounds(input int n);
    return (n == 0 || n > 12) ? 12 : n;
  endfunction

  function automatic int exp_latency(input int a);
`ifdef ASCON_PINV_FAST_LINV_EN
    return 1 + 2 * a;
`else
    return 1 + 7 * a;
`endif
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
    return s;
  endfunction

  // Runs one job from the current sample point (just after a rising edge).
  task automatic run_job(input string tag, input st_t din, input logic [3:0] nr,
                         input st_t exp, input int lat, input bit pulse10);
    int cyc;
    start_i   = 1'b1;
    state_i   = din;
    nrounds_i = nr;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    state_i = rand_state();
    cyc = 1;
    check({tag, " busy"}, 64'(busy_o), 64'd1);
    while (done_o !== 1'b1 && cyc < 300) begin
      if (pulse10 && cyc == 10) begin
        start_i   = 1'b1;
        nrounds_i = 4'd1;
        state_i   = rand_state();
      end else begin
        start_i = 1'b0;
      end
      @(posedge clock_i); #1;
      cyc++;
    end
    start_i = 1'b0;
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " busy at done"}, 64'(busy_o), 64'd0);
    for (int i = 0; i < 5; i++) check($sformatf("%s x%0d", tag, i), state_o[i], exp[i]);
    // A start during the DONE cycle must be ignored.
    start_i = 1'b1;
    state_i = rand_state();
    @(posedge clock_i); #1;
    start_i = 1'b0;
    check({tag, " done pulse width"}, 64'(done_o), 64'd0);
    @(posedge clock_i); #1;
    check({tag, " idle after done"}, 64'(busy_o), 64'd0);
    check({tag, " hold x0"}, state_o[0], exp[0]);
    check({tag, " hold x4"}, state_o[4], exp[4]);
    $display("job %s nrounds=%0d latency=%0d x0=%h", tag, nr, cyc, state_o[0]);
  endtask

  initial begin
    st_t ref12, ref6, x, y;
    int  a, seen, rst_cyc;
    logic [3:0] nr;

    reset_i   = 1'b1;
    start_i   = 1'b0;
    nrounds_i = 4'd1;
    state_i   = '0;
    repeat (2) @(posedge clock_i);
    #1;
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    for (int i = 0; i < 5; i++) check($sformatf("reset x%0d", i), state_o[i], 64'd0);
    reset_i = 1'b0;
    @(posedge clock_i); #1;

    // Single round on the zero state.
    run_job("zero a1", '0, 4'd1,
            mk(64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFB4, 64'h0, 64'h0),
            exp_latency(1), 1'b0);

    ref12 = mk(64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0eff,
               64'h0011223344556677, 64'h8899aabbccddeeff);
    ref6  = mk(64'h598da474303d9164, 64'h7559456e06c73ad3, 64'h94beaba9335e441f,
               64'h8866d2abc492c960, 64'hc11bf1d12e77b520);

    // Full round trip, with a stray start while busy.
    run_job("trip a12", fwd_perm(ref12, 12), 4'd12, ref12, exp_latency(12), 1'b1);
    run_job("trip a6", fwd_perm(ref6, 6), 4'd6, ref6, exp_latency(6), 1'b0);
    run_job("clamp a0", fwd_perm(ref12, 12), 4'd0, ref12, exp_latency(12), 1'b0);

    // Asynchronous reset in the middle of a 12-round job.
`ifdef ASCON_PINV_FAST_LINV_EN
    rst_cyc = 15;
`else
    rst_cyc = 30;
`endif
    start_i   = 1'b1;
    state_i   = fwd_perm(ref12, 12);
    nrounds_i = 4'd12;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    seen = 0;
    for (int c = 1; c < rst_cyc; c++) begin
      if (done_o === 1'b1) seen++;
      @(posedge clock_i); #1;
    end
    #2;
    reset_i = 1'b1;
    #1;
    check("async rst busy", 64'(busy_o), 64'd0);
    check("async rst x0", state_o[0], 64'd0);
    check("async rst x2", state_o[2], 64'd0);
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done_o === 1'b1) seen++;
      @(posedge clock_i); #1;
    end
    check("no done after rst", 64'(seen), 64'd0);
    $display("job reset-abort at cycle %0d done_pulses=%0d", rst_cyc, seen);
    run_job("after rst", fwd_perm(ref6, 6), 4'd6, ref6, exp_latency(6), 1'b0);

    // Random round trips, including clamped round counts.
    for (int t = 0; t < 8; t++) begin
      nr = 4'($urandom_range(0, 15));
      a  = eff_rounds(int'(nr));
      x  = rand_state();
      y  = fwd_perm(x, a);
      run_job($sformatf("rand%0d", t), y, nr, x, exp_latency(a), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
